// File: rtl/control_pkg.sv
// Encodings shared by the multicycle CPU control FSM and its decoder.
// Opcode, state and mux-select constants live here.
package control_pkg;

  typedef enum logic [4:0] {
    FETCH    = 5'd0,
    DECODE   = 5'd1,
    R_EXEC   = 5'd2,
    R_WB     = 5'd3,
    IMM_EXEC = 5'd4,
    IMM_WB   = 5'd5,
    MEM_ADDR = 5'd6,
    LW_READ  = 5'd7,
    LW_WB    = 5'd8,
    SW_WRITE = 5'd9,
    BEQ      = 5'd10,
    BNE      = 5'd11,
    JUMP     = 5'd12,
    JAL      = 5'd13,
    JR       = 5'd14,
    LUI_WB   = 5'd15,
    RETI     = 5'd16,
    INT_SAVE = 5'd17
  } state_t;

  typedef enum logic [3:0] {
    OP_R    = 4'd0,
    OP_ADDI = 4'd1,
    OP_ANDI = 4'd2,
    OP_ORI  = 4'd3,
    OP_SLTI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_J    = 4'd9,
    OP_JAL  = 4'd10,
    OP_JR   = 4'd11,
    OP_LUI  = 4'd12,
    OP_RETI = 4'd13
  } opcode_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_TWO  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  localparam logic [2:0] IORD_PC  = 3'd0;
  localparam logic [2:0] IORD_ALU = 3'd1;

  localparam logic [2:0] PC_ALU    = 3'd0;
  localparam logic [2:0] PC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_REGA   = 3'd3;
  localparam logic [2:0] PC_EPC    = 3'd4;
  localparam logic [2:0] PC_VEC    = 3'd5;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;
  localparam logic [1:0] WD_UIMM   = 2'd3;

  localparam logic [1:0] WA_RD  = 2'd0;
  localparam logic [1:0] WA_RT  = 2'd1;
  localparam logic [1:0] WA_R15 = 2'd2;

  typedef struct packed {
    logic [3:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       signExt;
    logic [2:0] iorD;
    logic       memRead;
    logic       memWrite;
    logic       iRegWrite;
    logic       gRegWrite;
    logic       pcWrite;
    logic       pcWriteBeq;
    logic       pcWriteBne;
    logic       epcWrite;
    logic [2:0] pcData;
    logic [1:0] writeData;
    logic [1:0] writeAddr;
    logic [1:0] memWriteData;
    logic       clr;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: IR fields and interrupt status in,
// state and every mux select / write enable out.
interface multicycle_control_if;
  logic [3:0] Opcode;
  logic [3:0] Functioncode;
  logic       InterruptIn;
  logic       InterruptHandler;
  logic [4:0] current_state;
  logic [4:0] next_state;
  logic [3:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       SignExt;
  logic [2:0] IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRegWrite;
  logic       GRegWrite;
  logic       PCWrite;
  logic       PCWriteBeq;
  logic       PCWriteBne;
  logic       EPCWrite;
  logic [2:0] PCData;
  logic [1:0] WriteData;
  logic [1:0] WriteAddr;
  logic [1:0] MemWriteData;
  logic       CLR;

  modport master (
    input  Opcode, Functioncode,
    input  InterruptIn, InterruptHandler,
    output current_state, next_state,
    output ALUOp, ALUSrcA, ALUSrcB, SignExt,
    output IorD, MemRead, MemWrite,
    output IRegWrite, GRegWrite,
    output PCWrite, PCWriteBeq, PCWriteBne,
    output EPCWrite, PCData, WriteData,
    output WriteAddr, MemWriteData, CLR
  );

  modport slave (
    output Opcode, Functioncode,
    output InterruptIn, InterruptHandler,
    input  current_state, next_state,
    input  ALUOp, ALUSrcA, ALUSrcB, SignExt,
    input  IorD, MemRead, MemWrite,
    input  IRegWrite, GRegWrite,
    input  PCWrite, PCWriteBeq, PCWriteBne,
    input  EPCWrite, PCData, WriteData,
    input  WriteAddr, MemWriteData, CLR
  );
endinterface

// File: rtl/control_decode.sv
// State/opcode to control-word decoder for the multicycle CPU.
// INTERRUPT_EN enables the EPCWrite/CLR outputs of INT_SAVE.
module control_decode
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [3:0] funct,
  output ctrl_t      cw
);

  logic logicOp;
  assign logicOp = (opcode == OP_ANDI) ||
                   (opcode == OP_ORI);

  always_comb begin
    cw = '0;
    unique case (1'b1)
      (state == FETCH): begin
        cw.memRead   = 1'b1;
        cw.iorD      = IORD_PC;
        cw.iRegWrite = 1'b1;
        cw.aluSrcB   = SRCB_TWO;
        cw.aluOp     = ALU_ADD;
        cw.pcWrite   = 1'b1;
        cw.pcData    = PC_ALU;
      end
      (state == DECODE): begin
        cw.aluSrcB = SRCB_IMM2;
        cw.signExt = 1'b1;
      end
      (state == R_EXEC): begin
        cw.aluSrcA = 1'b1;
        cw.aluOp   = funct;
      end
      (state == IMM_EXEC): begin
        cw.aluSrcA = 1'b1;
        cw.aluSrcB = SRCB_IMM;
        cw.signExt = !logicOp;
        if (opcode == OP_ANDI)
          cw.aluOp = ALU_AND;
        else if (opcode == OP_ORI)
          cw.aluOp = ALU_OR;
        else if (opcode == OP_SLTI)
          cw.aluOp = ALU_SLT;
      end
      (state == MEM_ADDR): begin
        cw.aluSrcA = 1'b1;
        cw.aluSrcB = SRCB_IMM;
        cw.signExt = 1'b1;
      end
      (state == R_WB): begin
        cw.gRegWrite = 1'b1;
        cw.writeAddr = WA_RD;
      end
      (state == IMM_WB): begin
        cw.gRegWrite = 1'b1;
        cw.writeAddr = WA_RT;
      end
      (state == LW_READ): begin
        cw.memRead = 1'b1;
        cw.iorD    = IORD_ALU;
      end
      (state == LW_WB): begin
        cw.gRegWrite = 1'b1;
        cw.writeData = WD_MDR;
        cw.writeAddr = WA_RT;
      end
      (state == SW_WRITE): begin
        cw.memWrite = 1'b1;
        cw.iorD     = IORD_ALU;
      end
      (state == BEQ): begin
        cw.aluSrcA    = 1'b1;
        cw.aluOp      = ALU_SUB;
        cw.pcData     = PC_ALUOUT;
        cw.pcWriteBeq = 1'b1;
      end
      (state == BNE): begin
        cw.aluSrcA    = 1'b1;
        cw.aluOp      = ALU_SUB;
        cw.pcData     = PC_ALUOUT;
        cw.pcWriteBne = 1'b1;
      end
      (state == JUMP): begin
        cw.pcWrite = 1'b1;
        cw.pcData  = PC_JUMP;
      end
      (state == JAL): begin
        // link and jump share the cycle; regfile still sees old PC
        cw.gRegWrite = 1'b1;
        cw.writeData = WD_PC;
        cw.writeAddr = WA_R15;
        cw.pcWrite   = 1'b1;
        cw.pcData    = PC_JUMP;
      end
      (state == JR): begin
        cw.pcWrite = 1'b1;
        cw.pcData  = PC_REGA;
      end
      (state == LUI_WB): begin
        cw.gRegWrite = 1'b1;
        cw.writeData = WD_UIMM;
        cw.writeAddr = WA_RT;
      end
      (state == RETI): begin
        cw.pcWrite = 1'b1;
        cw.pcData  = PC_EPC;
      end
      (state == INT_SAVE): begin
        cw.pcWrite = 1'b1;
        cw.pcData  = PC_VEC;
`ifdef INTERRUPT_EN
        cw.epcWrite = 1'b1;
        cw.clr      = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle CPU.
// Define INTERRUPT_EN to allow interrupt entry between instructions.
module multicycle_control
  import control_pkg::*;
(
  input logic CLK,
  input logic RST,
  multicycle_control_if.master bus
);

  state_t state;
  state_t nextState;
  state_t finalNext;
  ctrl_t  cw;
  ctrl_t  cwOut;
  logic   intTake;

`ifdef INTERRUPT_EN
  assign intTake = bus.InterruptIn &&
                   !bus.InterruptHandler;
`else
  logic unusedInt;
  assign unusedInt = bus.InterruptIn ^
                     bus.InterruptHandler;
  assign intTake = 1'b0;
`endif

  assign finalNext = intTake ? INT_SAVE : FETCH;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_R:    nextState = R_EXEC;
          OP_ADDI,
          OP_ANDI,
          OP_ORI,
          OP_SLTI: nextState = IMM_EXEC;
          OP_LW,
          OP_SW:   nextState = MEM_ADDR;
          OP_BEQ:  nextState = BEQ;
          OP_BNE:  nextState = BNE;
          OP_J:    nextState = JUMP;
          OP_JAL:  nextState = JAL;
          OP_JR:   nextState = JR;
          OP_LUI:  nextState = LUI_WB;
          OP_RETI: nextState = RETI;
          default: nextState = finalNext;
        endcase
      end
      R_EXEC:   nextState = R_WB;
      IMM_EXEC: nextState = IMM_WB;
      MEM_ADDR: nextState =
        (bus.Opcode == OP_LW) ? LW_READ : SW_WRITE;
      LW_READ:  nextState = LW_WB;
      R_WB, IMM_WB, LW_WB, SW_WRITE,
      BEQ, BNE, JUMP, JAL, JR,
      LUI_WB, RETI:
        nextState = finalNext;
      default:  nextState = FETCH;
    endcase
  end

  control_decode u_decode (
    .state  (state),
    .opcode (bus.Opcode),
    .funct  (bus.Functioncode),
    .cw     (cw)
  );

  assign cwOut = RST ? '0 : cw;

  assign bus.current_state = state;
  assign bus.next_state    = RST ? FETCH : nextState;
  assign bus.ALUOp         = cwOut.aluOp;
  assign bus.ALUSrcA       = cwOut.aluSrcA;
  assign bus.ALUSrcB       = cwOut.aluSrcB;
  assign bus.SignExt       = cwOut.signExt;
  assign bus.IorD          = cwOut.iorD;
  assign bus.MemRead       = cwOut.memRead;
  assign bus.MemWrite      = cwOut.memWrite;
  assign bus.IRegWrite     = cwOut.iRegWrite;
  assign bus.GRegWrite     = cwOut.gRegWrite;
  assign bus.PCWrite       = cwOut.pcWrite;
  assign bus.PCWriteBeq    = cwOut.pcWriteBeq;
  assign bus.PCWriteBne    = cwOut.pcWriteBne;
  assign bus.EPCWrite      = cwOut.epcWrite;
  assign bus.PCData        = cwOut.pcData;
  assign bus.WriteData     = cwOut.writeData;
  assign bus.WriteAddr     = cwOut.writeAddr;
  assign bus.MemWriteData  = cwOut.memWriteData;
  assign bus.CLR           = cwOut.clr;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a
// per-instruction state-path and control-table model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   path[$];
  bit   sawInt = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  function automatic bit takeInt(bit ii, bit hd);
`ifdef INTERRUPT_EN
    return ii && !hd;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void mkPath(int op, bit take);
    path = '{0, 1};
    case (op)
      0:         path = {path, 2, 3};
      1, 2, 3, 4: path = {path, 4, 5};
      5:         path = {path, 6, 7, 8};
      6:         path = {path, 6, 9};
      7:  path.push_back(10);
      8:  path.push_back(11);
      9:  path.push_back(12);
      10: path.push_back(13);
      11: path.push_back(14);
      12: path.push_back(15);
      13: path.push_back(16);
      default: ;
    endcase
    if (take) path.push_back(17);
  endfunction

  // {MemRead,MemWrite,IRegWrite,GRegWrite,PCWrite,
  //  PCWriteBeq,PCWriteBne,EPCWrite,CLR}
  function automatic int expEn(int st);
    case (st)
      0:  return 9'b101010000;
      3, 5, 8, 15: return 9'b000100000;
      7:  return 9'b100000000;
      9:  return 9'b010000000;
      10: return 9'b000001000;
      11: return 9'b000000100;
      12, 14, 16: return 9'b000010000;
      13: return 9'b000110000;
`ifdef INTERRUPT_EN
      17: return 9'b000010011;
`else
      17: return 9'b000010000;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int expPc(int st);
    case (st)
      10, 11: return 1;
      12, 13: return 2;
      14: return 3;
      16: return 4;
      17: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int expAlu(int st, int op, int fn);
    if (st == 2) return fn;
    if (st == 10 || st == 11) return 1;
    if (st == 4)
      return (op == 2) ? 2 : (op == 3) ? 3 :
             (op == 4) ? 4 : 0;
    return 0;
  endfunction

  function automatic int expWd(int st);
    return (st == 8) ? 1 : (st == 13) ? 2 :
           (st == 15) ? 3 : 0;
  endfunction

  function automatic int expWa(int st);
    return (st == 5 || st == 8 || st == 15) ? 1 :
           (st == 13) ? 2 : 0;
  endfunction

  function automatic int expSrcB(int st);
    return (st == 0) ? 1 : (st == 1) ? 3 :
           (st == 4 || st == 6) ? 2 : 0;
  endfunction

  function automatic int expSext(int st, int op);
    if (st == 1 || st == 6) return 1;
    if (st == 4) return (op != 2 && op != 3);
    return 0;
  endfunction

  function automatic int enVec();
    return {bus.MemRead, bus.MemWrite, bus.IRegWrite,
            bus.GRegWrite, bus.PCWrite, bus.PCWriteBeq,
            bus.PCWriteBne, bus.EPCWrite, bus.CLR};
  endfunction

  task automatic checkOuts(int st, int op, int fn);
    bit srcA;
    srcA = (st == 2 || st == 4 || st == 6 ||
            st == 10 || st == 11);
    check("enables", enVec(), expEn(st));
    check("PCData", bus.PCData, expPc(st));
    check("ALUOp", bus.ALUOp, expAlu(st, op, fn));
    check("WriteData", bus.WriteData, expWd(st));
    check("WriteAddr", bus.WriteAddr, expWa(st));
    check("ALUSrcA", bus.ALUSrcA, srcA);
    check("ALUSrcB", bus.ALUSrcB, expSrcB(st));
    check("SignExt", bus.SignExt, expSext(st, op));
    check("IorD", bus.IorD,
          (st == 7 || st == 9) ? 1 : 0);
    check("MemWriteData", bus.MemWriteData, 0);
  endtask

  // Entered at a negedge with the DUT in FETCH.
  task automatic runInstr(int op, int fn, bit ii, bit hd);
    int nxt;
    bus.Opcode = 4'(op);
    bus.Functioncode = 4'(fn);
    bus.InterruptIn = ii;
    bus.InterruptHandler = hd;
    mkPath(op, takeInt(ii, hd));
    foreach (path[k]) begin
      #1;
      nxt = (k + 1 < path.size()) ? path[k+1] : 0;
      check("state", bus.current_state, path[k]);
      check("next", bus.next_state, nxt);
      checkOuts(path[k], op, fn);
      if (bus.current_state == 5'd17) sawInt = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic checkReset(string tag);
    check({tag, "_state"}, bus.current_state, 0);
    check({tag, "_next"}, bus.next_state, 0);
    check({tag, "_en"}, enVec(), 0);
    check({tag, "_pcdata"}, bus.PCData, 0);
    check({tag, "_srcb"}, bus.ALUSrcB, 0);
  endtask

  initial begin
    bus.Opcode = 4'd0;
    bus.Functioncode = 4'd0;
    bus.InterruptIn = 1'b0;
    bus.InterruptHandler = 1'b0;
    #3;
    checkReset("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_pcw", bus.PCWrite, 1);
    check("rel_irw", bus.IRegWrite, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkReset("rst1");
    @(negedge clk);
    rst = 1'b0;

    runInstr(0, 1, 0, 0);
    runInstr(5, 3, 0, 0);
    runInstr(6, 0, 0, 0);
    runInstr(8, 0, 1, 0);
    runInstr(8, 0, 1, 1);
    runInstr(14, 0, 0, 0);
    runInstr(13, 0, 0, 0);
    runInstr(2, 0, 1, 0);

    // abort an lw in MEM_ADDR with an asynchronous reset
    bus.Opcode = 4'd5;
    bus.InterruptIn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_pre", bus.current_state, 6);
    #2;
    rst = 1'b1;
    #1;
    checkReset("rst2");
    @(posedge clk);
    #1;
    checkReset("rst3");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 300; i++)
      runInstr($urandom_range(0, 15),
               $urandom_range(0, 15),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));

`ifndef INTERRUPT_EN
    check("no_int_save", sawInt, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
